// File: rtl/nn_ram_loader.sv
// nn_ram_loader: packs a little-endian byte stream into BW-bit words and writes NBLK RAM blocks in order.
// Latency: wr pulses the cycle after a word's last byte transfers; done pulses in FIN.
// Backpressure: in_valid low stalls without state change. Optional checksum: NN_LOADER_CHKSUM_EN.
module nn_ram_loader #(
    parameter int BW   = 32,
    parameter int AW   = 8,
    parameter int NBLK = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [AW-1:0]   adrr_wr,
    output logic [BW-1:0]   data_wr,
    output logic [NBLK-1:0] wr,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int NB = BW / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

`ifdef NN_LOADER_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHK, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
`endif

    state_t        state;
    logic [CW-1:0] bcnt;
    logic [AW-1:0] addr;
    logic [1:0]    blk;
    logic [BW-1:0] word;
    logic [BW-1:0] nxt_word;
    logic          xfer;
    logic          last_byte;
    logic          last_word;

`ifdef NN_LOADER_CHKSUM_EN
    logic [7:0] sum;
    assign in_ready = (state == LOAD) || (state == CHK);
`else
    // drain: the final word's wr cycle, so done lands one cycle after the last wr
    logic drain;
    assign in_ready = (state == LOAD) && !drain;
    assign err      = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign xfer      = in_valid && in_ready;
    assign last_byte = (bcnt == CW'(NB - 1));
    assign last_word = (addr == {AW{1'b1}}) && (blk == 2'(NBLK - 1));

    always_comb begin
        nxt_word = word;
        nxt_word[8*int'(bcnt) +: 8] = in_data;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            bcnt    <= '0;
            addr    <= '0;
            blk     <= '0;
            word    <= '0;
            adrr_wr <= '0;
            data_wr <= '0;
            wr      <= '0;
            done    <= 1'b0;
`ifdef NN_LOADER_CHKSUM_EN
            sum     <= '0;
            err     <= 1'b0;
`else
            drain   <= 1'b0;
`endif
        end else begin
            wr   <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        bcnt  <= '0;
                        addr  <= '0;
                        blk   <= '0;
`ifdef NN_LOADER_CHKSUM_EN
                        sum   <= '0;
                        err   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
`ifndef NN_LOADER_CHKSUM_EN
                    if (drain) begin
                        drain <= 1'b0;
                        state <= FIN;
                        done  <= 1'b1;
                    end
`endif
                    if (xfer) begin
                        word <= nxt_word;
`ifdef NN_LOADER_CHKSUM_EN
                        sum  <= sum + in_data;
`endif
                        if (last_byte) begin
                            bcnt    <= '0;
                            data_wr <= nxt_word;
                            adrr_wr <= addr;
                            wr      <= NBLK'(1) << blk;
                            addr    <= addr + AW'(1);
                            if (addr == {AW{1'b1}}) begin
                                blk <= blk + 2'd1;
                            end
                            if (last_word) begin
`ifdef NN_LOADER_CHKSUM_EN
                                state <= CHK;
`else
                                drain <= 1'b1;
`endif
                            end
                        end else begin
                            bcnt <= bcnt + CW'(1);
                        end
                    end
                end
`ifdef NN_LOADER_CHKSUM_EN
                CHK: begin
                    if (xfer) begin
                        err   <= (in_data != sum);
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
`endif
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_ram_loader.sv
// Bench for nn_ram_loader (AW=2, NBLK=2, BW=32): randomized byte streams checked against a word-list model.
`timescale 1ns/1ps
module tb_nn_ram_loader;
    localparam int BW = 32, AW = 2, NBLK = 2;
    localparam int NWB = 2 ** AW;
    localparam int NW = NBLK * NWB;
    localparam int NBYTE = NW * BW / 8;

    logic            Clk = 1'b0;
    logic            Rst, start, in_valid, in_ready, busy, done, err;
    logic [7:0]      in_data;
    logic [AW-1:0]   adrr_wr;
    logic [BW-1:0]   data_wr;
    logic [NBLK-1:0] wr;

    always #5 Clk = ~Clk;

    nn_ram_loader #(.BW(BW), .AW(AW), .NBLK(NBLK)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .adrr_wr(adrr_wr), .data_wr(data_wr), .wr(wr),
        .busy(busy), .done(done), .err(err)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [NBLK-1:0] w;
        logic [AW-1:0]   a;
        logic [BW-1:0]   d;
        int              c;
    } wrec_t;

    wrec_t wq[$];
    int    done_cyc[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

    always @(negedge Clk) begin
        cyc++;
        if (wr !== '0) wq.push_back('{w: wr, a: adrr_wr, d: data_wr, c: cyc});
        if (done === 1'b1) done_cyc.push_back(cyc);
    end

    // Model: word k is bytes 4k..4k+3 little-endian, block k/2**AW, address k%2**AW
    function automatic logic [BW-1:0] exp_data(input bq_t b, input int k);
        logic [BW-1:0] r;
        for (int j = 0; j < BW / 8; j++) r[8*j +: 8] = b[k*(BW/8) + j];
        return r;
    endfunction
    function automatic logic [NBLK-1:0] exp_wr(input int k);
        logic [NBLK-1:0] r = '0;
        r[k / NWB] = 1'b1;
        return r;
    endfunction
    function automatic logic [AW-1:0] exp_adr(input int k);
        return AW'(k % NWB);
    endfunction
    function automatic logic [7:0] sum8(input bq_t b);
        int s = 0;
        foreach (b[i]) s += int'(b[i]);
        return 8'(s % 256);
    endfunction
    function automatic wrec_t get_rec(input int k);
        wrec_t r = '{w: '0, a: '0, d: '0, c: -1};
        if (k < wq.size()) r = wq[k];
        return r;
    endfunction

    // mode 0: in_valid always high, 1: every other cycle, 2: random
    task automatic run_load(input bq_t b, input int mode, input int start_at,
                            input logic [7:0] ck, output bit ok);
        bq_t q = b;
        int  i = 0, g = 0;
        bit  acc;
`ifdef NN_LOADER_CHKSUM_EN
        q.push_back(ck);
`else
        if (ck === 8'hxx) q.push_back(ck);
`endif
        wq.delete();
        done_cyc.delete();
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        while (i < q.size() && g < 4000) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 2) == 0) : 1'($urandom_range(0, 1));
            in_data  = in_valid ? q[i] : 8'($urandom);
            start    = (start_at >= 0 && i == start_at);
            @(negedge Clk);
            acc = in_valid && in_ready;
            @(posedge Clk); #1;
            if (acc) i++;
            g++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge Clk); #1;
            if (done_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(posedge Clk);
        #1;
        ok = ok && (i == q.size());
    endtask

    task automatic test_reset();
        Rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", in_ready); end
        checks++; if (wr !== '0) begin errors++; $display("FAIL reset wr: got %b want 00", wr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
        checks++; if (adrr_wr !== '0) begin errors++; $display("FAIL reset adrr_wr: got %0d want 0", adrr_wr); end
        checks++; if (data_wr !== '0) begin errors++; $display("FAIL reset data_wr: got %h want 0", data_wr); end
        Rst = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_back_to_back();
        bq_t b;
        bit ok, sp;
        wrec_t r;
        for (int i = 0; i < NBYTE; i++) b.push_back(8'(i + 1));
        run_load(b, 0, -1, sum8(b), ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b done: timed out, got no done want done"); end
        checks++; if (wq.size() != NW) begin errors++; $display("FAIL b2b count: got %0d writes want %0d", wq.size(), NW); end
        for (int k = 0; k < NW; k++) begin
            r = get_rec(k);
            checks++;
            if (r.w !== exp_wr(k) || r.a !== exp_adr(k) || r.d !== exp_data(b, k)) begin
                errors++;
                $display("FAIL b2b word%0d: got wr=%b adr=%0d dat=%h want wr=%b adr=%0d dat=%h",
                         k, r.w, r.a, r.d, exp_wr(k), exp_adr(k), exp_data(b, k));
            end
        end
        sp = 1'b1;
        for (int k = 1; k < NW; k++) if (get_rec(k).c - get_rec(k - 1).c != BW / 8) sp = 1'b0;
        checks++; if (!sp) begin errors++; $display("FAIL b2b rate: got uneven write spacing want %0d cycles", BW / 8); end
        r = get_rec(NW - 1);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != r.c + 1) begin
            errors++;
            $display("FAIL b2b done timing: got %0d pulses first at %0d want 1 pulse at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, r.c + 1);
        end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b idle: got busy=%b in_ready=%b want 0 0", busy, in_ready); end
    endtask

    task automatic test_stall();
        bq_t b;
        bit ok, sp;
        wrec_t r;
        for (int i = 0; i < NBYTE; i++) b.push_back(8'(i + 1));
        run_load(b, 1, -1, sum8(b), ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall done: timed out, got no done want done"); end
        checks++; if (wq.size() != NW) begin errors++; $display("FAIL stall count: got %0d writes want %0d", wq.size(), NW); end
        for (int k = 0; k < NW; k++) begin
            r = get_rec(k);
            checks++;
            if (r.w !== exp_wr(k) || r.a !== exp_adr(k) || r.d !== exp_data(b, k)) begin
                errors++;
                $display("FAIL stall word%0d: got wr=%b adr=%0d dat=%h want wr=%b adr=%0d dat=%h",
                         k, r.w, r.a, r.d, exp_wr(k), exp_adr(k), exp_data(b, k));
            end
        end
        sp = 1'b1;
        for (int k = 1; k < NW; k++) if (get_rec(k).c - get_rec(k - 1).c != 2 * BW / 8) sp = 1'b0;
        checks++; if (!sp) begin errors++; $display("FAIL stall spacing: got uneven spacing want %0d cycles", 2 * BW / 8); end
    endtask

    task automatic test_reset_midload();
        bq_t b;
        bit ok;
        wrec_t r;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 6; n++) begin
            in_data = 8'(8'h51 + n);
            @(posedge Clk); #1;
        end
        in_valid = 1'b0;
        Rst = 1'b1;
        wq.delete();
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rstmid wr after reset: got %0d writes want 0", wq.size()); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid idle: got busy=%b in_ready=%b want 0 0", busy, in_ready); end
        for (int i = 0; i < NBYTE; i++) b.push_back(8'hAA);
        run_load(b, 0, -1, sum8(b), ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid done: timed out, got no done want done"); end
        for (int k = 0; k < NW; k++) begin
            r = get_rec(k);
            checks++;
            if (r.w !== exp_wr(k) || r.a !== exp_adr(k) || r.d !== exp_data(b, k)) begin
                errors++;
                $display("FAIL rstmid word%0d: got wr=%b adr=%0d dat=%h want wr=%b adr=%0d dat=%h",
                         k, r.w, r.a, r.d, exp_wr(k), exp_adr(k), exp_data(b, k));
            end
        end
    endtask

    task automatic test_start_ignored();
        bq_t b;
        bit ok;
        wrec_t r;
        for (int i = 0; i < NBYTE; i++) b.push_back(8'($urandom));
        run_load(b, 0, 10, sum8(b), ok);
        checks++; if (!ok) begin errors++; $display("FAIL midstart done: timed out, got no done want done"); end
        checks++; if (wq.size() != NW) begin errors++; $display("FAIL midstart count: got %0d writes want %0d", wq.size(), NW); end
        for (int k = 0; k < NW; k++) begin
            r = get_rec(k);
            checks++;
            if (r.w !== exp_wr(k) || r.a !== exp_adr(k) || r.d !== exp_data(b, k)) begin
                errors++;
                $display("FAIL midstart word%0d: got wr=%b adr=%0d dat=%h want wr=%b adr=%0d dat=%h",
                         k, r.w, r.a, r.d, exp_wr(k), exp_adr(k), exp_data(b, k));
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        wrec_t r;
        for (int it = 0; it < 3; it++) begin
            bq_t b;
            for (int i = 0; i < NBYTE; i++) b.push_back(8'($urandom));
            run_load(b, 2, -1, sum8(b), ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d done: timed out, got no done want done", it); end
            checks++; if (wq.size() != NW) begin errors++; $display("FAIL rand%0d count: got %0d writes want %0d", it, wq.size(), NW); end
            for (int k = 0; k < NW; k++) begin
                r = get_rec(k);
                checks++;
                if (r.w !== exp_wr(k) || r.a !== exp_adr(k) || r.d !== exp_data(b, k)) begin
                    errors++;
                    $display("FAIL rand%0d word%0d: got wr=%b adr=%0d dat=%h want wr=%b adr=%0d dat=%h",
                             it, k, r.w, r.a, r.d, exp_wr(k), exp_adr(k), exp_data(b, k));
                end
            end
        end
    endtask

    task automatic test_checksum();
        bq_t b;
        bit ok;
        for (int i = 0; i < NBYTE; i++) b.push_back(8'(i + 1));
`ifdef NN_LOADER_CHKSUM_EN
        run_load(b, 0, -1, sum8(b), ok);
        checks++; if (!ok) begin errors++; $display("FAIL chk good done: timed out, got no done want done"); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk good err: got %b want 0", err); end
        run_load(b, 0, -1, sum8(b) ^ 8'h01, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chk bad done: timed out, got no done want done"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk bad err: got %b want 1", err); end
        repeat (4) @(posedge Clk);
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL chk err hold: got %b want 1", err); end
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk err clear: got %b want 0", err); end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
`else
        run_load(b, 2, -1, 8'h00, ok);
        checks++; if (!ok) begin errors++; $display("FAIL errtie done: timed out, got no done want done"); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL errtie err: got %b want 0", err); end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_reset_midload();
        test_start_ignored();
        test_random();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
